key_debounce_pulse: RTL and testbench

//  Upstream front end for the pulse_extender_cycles stage. Takes one raw

---
 rtl/pacman_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/key_debounce_pulse.sv | 123 ++++++++++++
 tb/tb_key_debounce_pulse.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared types and board-clock timing constants for the pacman front-end blocks.
package pacman_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } key_state_t;

  // Defaults for the 50 MHz board clock: 10 ms debounce, 0.5 s delay, 0.1 s rate.
  localparam int KEY_DEBOUNCE_CYCLES_DEF = 500_000;
  localparam int KEY_REPEAT_DELAY_DEF    = 25_000_000;
  localparam int KEY_REPEAT_RATE_DEF     = 5_000_000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-low reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetN,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce_pulse.sv
// Push-button front end: synchronise, debounce press/release, and emit
// single-cycle press, typematic-repeat and release pulses.
module key_debounce_pulse
  import pacman_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = KEY_DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY_CYCLES = KEY_REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE_CYCLES  = KEY_REPEAT_RATE_DEF,
  parameter bit REPEAT_EN           = 1'b1,
  parameter bit KEY_ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic resetN,
  input  logic key_in,
  output logic key_pressed,
  output logic key_pulse,
  output logic key_released
);

  localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DEB_LAST   = cnt_t'(DEBOUNCE_CYCLES - 1);
  localparam cnt_t DELAY_LAST = cnt_t'(REPEAT_DELAY_CYCLES - 1);
  localparam cnt_t RATE_LAST  = cnt_t'(REPEAT_RATE_CYCLES - 1);
  localparam cnt_t CNT_TOP    = cnt_t'(CNT_MAX);

  key_state_t state, state_next;
  cnt_t       cnt, cnt_next, cnt_inc;
  logic       key_raw, key_s;
  logic       pulse_req, pulse_next, pressed_next, released_next;

  // Normalise polarity before synchronising so the reset value means "not pressed".
  assign key_raw = KEY_ACTIVE_LOW ? ~key_in : key_in;

  sync_2ff #(.RESET_VAL(1'b0)) u_sync (
    .clk    (clk),
    .resetN (resetN),
    .d      (key_raw),
    .q      (key_s)
  );

  assign cnt_inc = (cnt == CNT_TOP) ? cnt : cnt + cnt_t'(1);

  always_comb begin
    state_next    = state;
    cnt_next      = cnt_inc;
    pulse_req     = 1'b0;
    released_next = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (key_s) state_next = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == DEB_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          pulse_req  = 1'b1;
        end
      end
      HELD: begin
        if (!key_s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end else if (REPEAT_EN && (cnt == DELAY_LAST)) begin
          state_next = REPEAT;
          cnt_next   = '0;
          pulse_req  = 1'b1;
        end
      end
      REPEAT: begin
        if (!key_s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end else if (cnt == RATE_LAST) begin
          cnt_next  = '0;
          pulse_req = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt == DEB_LAST) begin
          state_next    = IDLE;
          cnt_next      = '0;
          released_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    pressed_next = (state_next == HELD) || (state_next == REPEAT) ||
                   (state_next == RELEASE_WAIT);
    // With one-cycle delay/rate settings a pulse could otherwise follow a pulse.
    pulse_next   = pulse_req & ~key_pulse;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      cnt          <= '0;
      key_pressed  <= 1'b0;
      key_pulse    <= 1'b0;
      key_released <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      key_pressed  <= pressed_next;
      key_pulse    <= pulse_next;
      key_released <= released_next;
    end
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse: table of press/bounce vectors plus
// hand-written repeat, release, release-bounce, reset and no-repeat sequences.
module tb_key_debounce_pulse;

  logic clk = 1'b0;
  logic resetN;
  logic key_in;
  logic key_pressed, key_pulse, key_released;
  logic key2_in;
  logic key_pressed2, key_pulse2, key_released2;

  int checks = 0;
  int errors = 0;
  int pulse2_count = 0;
  logic prev_pulse = 1'b0;
  logic prev_pressed = 1'b0;

  typedef struct {
    logic key;
    logic pulse;
    logic pressed;
    logic released;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY_CYCLES(10), .REPEAT_RATE_CYCLES(3),
    .REPEAT_EN(1'b1), .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .resetN(resetN), .key_in(key_in),
    .key_pressed(key_pressed), .key_pulse(key_pulse), .key_released(key_released)
  );

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY_CYCLES(10), .REPEAT_RATE_CYCLES(3),
    .REPEAT_EN(1'b0), .KEY_ACTIVE_LOW(1'b1)
  ) dut_norep (
    .clk(clk), .resetN(resetN), .key_in(key2_in),
    .key_pressed(key_pressed2), .key_pulse(key_pulse2), .key_released(key_released2)
  );

  // Continuous protocol checks on the main instance; also tally no-repeat pulses.
  always @(negedge clk) begin
    if (key_pulse) begin
      checks++;
      if (prev_pulse) begin
        errors++;
        $display("[TB] FAIL pulse_consecutive at %0t: key_pulse high two cycles, required single", $time);
      end
    end
    if (key_released) begin
      checks++;
      if (key_pressed || !prev_pressed) begin
        errors++;
        $display("[TB] FAIL released_edge at %0t: pressed prev/now %b/%b, required 1/0",
                 $time, prev_pressed, key_pressed);
      end
    end
    prev_pulse   = key_pulse;
    prev_pressed = key_pressed;
    if (key_pulse2) pulse2_count++;
  end

  task automatic applyStimulus(input logic k);
    key_in = k;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ep, input logic epr, input logic er);
    checks++;
    if ({key_pulse, key_pressed, key_released} !== {ep, epr, er}) begin
      errors++;
      $display("[TB] FAIL %s: pulse/pressed/released got %b%b%b required %b%b%b",
               name, key_pulse, key_pressed, key_released, ep, epr, er);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic k, input logic p, input logic pr, input logic r);
    vec_t v;
    v.key = k; v.pulse = p; v.pressed = pr; v.released = r;
    vecs.push_back(v);
  endtask

  initial begin
    // Bounce: low 3, high 2, low 3, then high long enough to settle.
    for (int i = 0; i < 3; i++) addVec(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) addVec(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) addVec(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) addVec(1'b1, 1'b0, 1'b0, 1'b0);
    // Clean press: pulse and pressed appear after the 7th sampling edge.
    for (int e = 1; e <= 8; e++) addVec(1'b0, (e == 7), (e >= 7), 1'b0);

    resetN  = 1'b0;
    key_in  = 1'b1;
    key2_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", 1'b0, 1'b0, 1'b0);
    checkValue("reset_state_norep", {29'd0, key_pulse2, key_pressed2, key_released2}, 0);
    resetN = 1'b1;

    $display("[TB] bounce and clean press vectors");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].key);
      checkOutput($sformatf("vec%0d", i), vecs[i].pulse, vecs[i].pressed, vecs[i].released);
    end

    // Repeat: acceptance was edge 7; first repeat at 17, then every 3 edges.
    $display("[TB] typematic repeat");
    for (int e = 9; e <= 47; e++) begin
      applyStimulus(1'b0);
      checkOutput($sformatf("repeat_e%0d", e),
                  (e == 17) || ((e > 17) && ((e - 17) % 3 == 0)), 1'b1, 1'b0);
    end

    // Release right after a repeat pulse: no further pulse before RELEASE_WAIT.
    $display("[TB] release");
    for (int r = 1; r <= 8; r++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("release_r%0d", r), 1'b0, (r < 7), (r == 7));
    end

    // Release bounce: key high for 2 edges after acceptance, back to HELD at edge 12.
    $display("[TB] release bounce");
    for (int e = 1; e <= 7; e++) begin
      applyStimulus(1'b0);
      checkOutput($sformatf("rb_press_e%0d", e), (e == 7), (e == 7), 1'b0);
    end
    for (int e = 8; e <= 22; e++) begin
      applyStimulus((e == 8) || (e == 9));
      checkOutput($sformatf("rb_hold_e%0d", e), (e == 22), 1'b1, 1'b0);
    end

    $display("[TB] reset while held");
    for (int r = 1; r <= 8; r++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("rst_release_r%0d", r), 1'b0, (r < 7), (r == 7));
    end
    for (int e = 1; e <= 10; e++) begin
      applyStimulus(1'b0);
      checkOutput($sformatf("rst_press_e%0d", e), (e == 7), (e >= 7), 1'b0);
    end
    resetN = 1'b0;
    #1;
    checkOutput("reset_mid_held", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      applyStimulus(1'b0);
      checkOutput($sformatf("requal_e%0d", e), (e == 7), (e >= 7), 1'b0);
    end

    $display("[TB] repeat disabled");
    checkValue("norep_idle_pulses", pulse2_count, 0);
    pulse2_count = 0;
    key2_in = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checkValue("norep_pulse_count", pulse2_count, 1);
    checkValue("norep_pressed", {31'd0, key_pressed2}, 1);

    key_in  = 1'b1;
    key2_in = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("final_idle", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
